// File: rtl/feature_pkg.sv
// Shared types and defaults for the feature-stream FWFT buffer.
package feature_pkg;
  localparam int FEATURE_W          = 8;
  localparam int FWFT_DEFAULT_DEPTH = 16;

  typedef logic [FEATURE_W-1:0] feature_t;
endpackage

// File: rtl/feature_fifo_mem.sv
// Storage behind the head register: synchronous write, asynchronous read, no reset.
module feature_fifo_mem
  import feature_pkg::*;
#(
  parameter int DATA_WIDTH = FEATURE_W,
  parameter int WORDS      = FWFT_DEFAULT_DEPTH - 1,
  parameter int AW         = 4
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/feature_fwft.sv
// First-word-fall-through buffer: head register plus a DEPTH-1 word memory.
// The input is sampled every clock; samples arriving while full are dropped.
module feature_fwft
  import feature_pkg::*;
#(
  parameter int DATA_WIDTH = FEATURE_W,
  parameter int DEPTH      = FWFT_DEFAULT_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] in_feature,
  output logic [DATA_WIDTH-1:0] out_feature
);

  localparam int MEM_WORDS = DEPTH - 1;
  localparam int AW        = $clog2(DEPTH);
  localparam int CW        = $clog2(DEPTH) + 1;

  logic [AW-1:0]         rd_ptr, wr_ptr;
  logic [CW-1:0]         count;
  logic                  head_valid;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic pop, accept, mem_empty, mem_we, load_mem, load_in, head_clr;

  // count includes the head word, so the memory holds count-1 words when the head is valid
  always_comb begin
    pop       = rd_en && head_valid;
    accept    = (count < CW'(DEPTH)) || pop;
    mem_empty = (count <= CW'(1));
    load_mem  = pop && !mem_empty;
    load_in   = accept && (!head_valid || (pop && mem_empty));
    head_clr  = pop && mem_empty && !accept;
    mem_we    = accept && head_valid && !(pop && mem_empty);
  end

  feature_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .WORDS      (MEM_WORDS),
    .AW         (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (mem_we),
    .wr_addr (wr_ptr),
    .wr_data (in_feature),
    .rd_addr (rd_ptr),
    .rd_data (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      head_valid  <= 1'b0;
      out_feature <= '0;
    end else begin
      if (load_in)       out_feature <= in_feature;
      else if (load_mem) out_feature <= mem_rdata;
      else if (head_clr) out_feature <= '0;

      if (load_in)       head_valid <= 1'b1;
      else if (head_clr) head_valid <= 1'b0;

      // memory depth is DEPTH-1, not a power of two, so wrap explicitly
      if (load_mem)
        rd_ptr <= (rd_ptr == AW'(MEM_WORDS - 1)) ? '0 : rd_ptr + 1'b1;
      if (mem_we)
        wr_ptr <= (wr_ptr == AW'(MEM_WORDS - 1)) ? '0 : wr_ptr + 1'b1;

      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_feature_fwft.sv
// Directed bench for feature_fwft with a queue-based reference for the head value.
module tb_feature_fwft;
  import feature_pkg::*;

  logic     clk = 1'b0;
  logic     rst;
  logic     rd_en;
  feature_t in_feature;
  feature_t out_feature;

  int errors = 0;
  int checks = 0;
  feature_t q[$];

  always #5 clk = ~clk;

  feature_fwft #(
    .DATA_WIDTH (8),
    .DEPTH      (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rd_en       (rd_en),
    .in_feature  (in_feature),
    .out_feature (out_feature)
  );

  task automatic chk(input string tag, input feature_t obs, input feature_t exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // One clock edge; the reference queue follows the sample/drop/pop rules.
  task automatic step(input logic r, input logic rd, input feature_t d);
    feature_t exp;
    rst        = r;
    rd_en      = rd;
    in_feature = d;
    @(posedge clk);
    #1;
    if (r) q.delete();
    else begin
      if (rd && q.size() > 0) void'(q.pop_front());
      if (q.size() < 16) q.push_back(d);
    end
    exp = (q.size() > 0) ? q[0] : 8'h00;
    chk("model_head", out_feature, exp);
  endtask

  initial begin
    // reset while the input toggles
    step(1'b1, 1'b0, 8'hAA);
    chk("reset_out", out_feature, 8'h00);
    step(1'b1, 1'b0, 8'h55);
    chk("reset_out", out_feature, 8'h00);

    // fall-through then fill: 0x00..0x0F stored, 0x10..0x13 dropped
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, feature_t'(i));
      chk("fill_head", out_feature, 8'h00);
    end

    // burst read at full while the stream continues
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, feature_t'(8'h14 + i));
      chk("burst_head", out_feature, feature_t'(8'h01 + i));
    end

    // continuous drain: remaining stored words, then the words taken during the burst
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, feature_t'(8'h19 + i));
      if (i < 10) chk("drain_head", out_feature, feature_t'(8'h06 + i));
      else        chk("drain_head", out_feature, feature_t'(8'h14 + i - 10));
    end

    // long run across pointer wrap and 0xFF->0x00 data wrap
    for (int i = 0; i < 1024; i++)
      step(1'b0, ((i % 15) >= 10), feature_t'(i));

    // reset, then read request on an empty queue is ignored
    step(1'b1, 1'b1, 8'h33);
    chk("rst_clear", out_feature, 8'h00);
    step(1'b0, 1'b1, 8'h77);
    chk("empty_rd", out_feature, 8'h77);
    step(1'b0, 1'b1, 8'h78);
    chk("pop_bypass", out_feature, 8'h78);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, feature_t'(8'h80 + i));
    chk("queued_head", out_feature, 8'h78);

    // reset with 8 words queued
    step(1'b1, 1'b0, 8'hAB);
    chk("rst_mid", out_feature, 8'h00);
    step(1'b0, 1'b0, 8'h99);
    chk("post_rst_first", out_feature, 8'h99);
    step(1'b0, 1'b0, 8'h9A);
    chk("post_rst_hold", out_feature, 8'h99);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
